conv_window_reader: RTL and testbench

// - Consumer side of the conv anchor interface: accepts a top-left anchor (row, col) from the conv controller.
// - Gathers the weight_length x weight_width window for every input channel from the flattened image bus, one element per clock.
// - Presents the assembled window to the MAC stage with a valid/ready handshake.

---
 rtl/conv_window_reader.sv | 182 ++++++++++++++++++
 tb/tb_conv_window_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_reader.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_reader
// Description : Accepts a top-left anchor and gathers a KLxKW window for every
//               channel from the flattened image, one element per clock, then
//               holds it for the MAC stage under a valid/ready handshake.
//               Optional zero padding / oob_err: CONV_WINDOW_BOUNDS_CHECK_EN
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_reader #(
    parameter int DATA_WIDTH    = 16,
    parameter int INPUT_CHANNEL = 2,
    parameter int IMAGE_LENGTH  = 4,
    parameter int IMAGE_WIDTH   = 4,
    parameter int WEIGHT_LENGTH = 3,
    parameter int WEIGHT_WIDTH  = 3,
    parameter int RESULT_LENGTH = 2,
    parameter int RESULT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  conv_en,
    input  logic [0:INPUT_CHANNEL*IMAGE_LENGTH*IMAGE_WIDTH*DATA_WIDTH-1] image,
    input  logic                  anchor_valid,
    input  logic [DATA_WIDTH-1:0] anchor_row,
    input  logic [DATA_WIDTH-1:0] anchor_col,
    output logic                  anchor_ready,
    output logic [0:INPUT_CHANNEL*WEIGHT_LENGTH*WEIGHT_WIDTH*DATA_WIDTH-1] window,
    output logic                  window_valid,
    input  logic                  window_ready,
    output logic                  window_last,
    output logic [15:0]           win_cnt,
    output logic                  oob_err
);

    localparam int c_num_elem  = INPUT_CHANNEL*WEIGHT_LENGTH*WEIGHT_WIDTH;
    localparam int c_img_elems = INPUT_CHANNEL*IMAGE_LENGTH*IMAGE_WIDTH;
    localparam int c_win_bits  = c_num_elem*DATA_WIDTH;

    localparam logic [7:0]  c_kw_last  = 8'(WEIGHT_WIDTH-1);
    localparam logic [7:0]  c_kl_last  = 8'(WEIGHT_LENGTH-1);
    localparam logic [7:0]  c_ch_last  = 8'(INPUT_CHANNEL-1);
    localparam logic [15:0] c_win_last = 16'(RESULT_LENGTH*RESULT_WIDTH-1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   row_q, row_d, col_q, col_d;
    logic [7:0]              ch_q, ch_d, kr_q, kr_d, kc_q, kc_d;
    logic [0:c_win_bits-1]   window_q, window_d;
    logic [15:0]             win_cnt_q, win_cnt_d;
    logic                    oob_acc_q, oob_acc_d;
    logic                    oob_err_q, oob_err_d;

    logic [DATA_WIDTH:0]     w_row_sum, w_col_sum;
    logic [31:0]             w_img_idx, w_slot_idx;
    logic [DATA_WIDTH-1:0]   w_elem;
    logic                    w_oob;

    // Sums carry one extra bit so a large anchor can never alias back into range.
    assign w_row_sum  = {1'b0, row_q} + (DATA_WIDTH+1)'(kr_q);
    assign w_col_sum  = {1'b0, col_q} + (DATA_WIDTH+1)'(kc_q);
    assign w_img_idx  = (32'(ch_q) * 32'(IMAGE_LENGTH) + 32'(w_row_sum)) * 32'(IMAGE_WIDTH)
                        + 32'(w_col_sum);
    assign w_slot_idx = (32'(ch_q) * 32'(WEIGHT_LENGTH) + 32'(kr_q)) * 32'(WEIGHT_WIDTH)
                        + 32'(kc_q);

    always_comb begin
        w_elem = '0;
        for (int k = 0; k < c_img_elems; k++) begin
            if (w_img_idx == 32'(k)) begin
                w_elem = image[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
`ifdef CONV_WINDOW_BOUNDS_CHECK_EN
        w_oob = (w_row_sum >= (DATA_WIDTH+1)'(IMAGE_LENGTH)) ||
                (w_col_sum >= (DATA_WIDTH+1)'(IMAGE_WIDTH));
        if (w_oob) begin
            w_elem = '0;
        end
`else
        w_oob = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        ch_d      = ch_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        window_d  = window_q;
        win_cnt_d = win_cnt_q;
        oob_acc_d = oob_acc_q;
        oob_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (anchor_valid) begin
                    row_d     = anchor_row;
                    col_d     = anchor_col;
                    ch_d      = '0;
                    kr_d      = '0;
                    kc_d      = '0;
                    oob_acc_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                for (int s = 0; s < c_num_elem; s++) begin
                    if (w_slot_idx == 32'(s)) begin
                        window_d[s*DATA_WIDTH +: DATA_WIDTH] = w_elem;
                    end
                end
                oob_acc_d = oob_acc_q | w_oob;
                if (kc_q == c_kw_last) begin
                    kc_d = '0;
                    if (kr_q == c_kl_last) begin
                        kr_d = '0;
                        if (ch_q == c_ch_last) begin
                            state_d   = ST_HOLD;
                            oob_err_d = oob_acc_q | w_oob;
                        end else begin
                            ch_d = ch_q + 8'd1;
                        end
                    end else begin
                        kr_d = kr_q + 8'd1;
                    end
                end else begin
                    kc_d = kc_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (window_ready) begin
                    state_d   = ST_IDLE;
                    win_cnt_d = (win_cnt_q == c_win_last) ? 16'd0 : win_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Dropping conv_en is an abort with exactly the same effect as reset.
    always_ff @(posedge clk) begin
        if (reset || !conv_en) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            ch_q      <= '0;
            kr_q      <= '0;
            kc_q      <= '0;
            window_q  <= '0;
            win_cnt_q <= '0;
            oob_acc_q <= 1'b0;
            oob_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ch_q      <= ch_d;
            kr_q      <= kr_d;
            kc_q      <= kc_d;
            window_q  <= window_d;
            win_cnt_q <= win_cnt_d;
            oob_acc_q <= oob_acc_d;
            oob_err_q <= oob_err_d;
        end
    end

    assign anchor_ready = (state_q == ST_IDLE) && !reset && conv_en;
    assign window       = window_q;
    assign window_valid = (state_q == ST_HOLD);
    assign window_last  = (state_q == ST_HOLD) && (win_cnt_q == c_win_last);
    assign win_cnt      = win_cnt_q;
    assign oob_err      = oob_err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_reader
// Description : Directed self-checking bench for conv_window_reader.
//               Bounds-check cases run when CONV_WINDOW_BOUNDS_CHECK_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_reader;

    localparam int DW = 16;
    localparam int C  = 2;
    localparam int IL = 4;
    localparam int IW = 4;
    localparam int KL = 3;
    localparam int KW = 3;
    localparam int N  = C*KL*KW;
    localparam int WB = N*DW;
    localparam int IB = C*IL*IW*DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          conv_en;
    logic [0:IB-1] image;
    logic          anchor_valid;
    logic [DW-1:0] anchor_row;
    logic [DW-1:0] anchor_col;
    logic          anchor_ready;
    logic [0:WB-1] window;
    logic          window_valid;
    logic          window_ready;
    logic          window_last;
    logic [15:0]   win_cnt;
    logic          oob_err;

    int            n_chk   = 0;
    int            n_pass  = 0;
    int            oob_cnt = 0;
    int            lat;
    int            exp_e[N];
    logic [0:WB-1] exp_w;
    int            ar[4];
    int            ac[4];
    int            cnt_seq[4];

    always #5 clk = ~clk;

    conv_window_reader #(
        .DATA_WIDTH   (DW),
        .INPUT_CHANNEL(C),
        .IMAGE_LENGTH (IL),
        .IMAGE_WIDTH  (IW),
        .WEIGHT_LENGTH(KL),
        .WEIGHT_WIDTH (KW),
        .RESULT_LENGTH(2),
        .RESULT_WIDTH (2)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .conv_en     (conv_en),
        .image       (image),
        .anchor_valid(anchor_valid),
        .anchor_row  (anchor_row),
        .anchor_col  (anchor_col),
        .anchor_ready(anchor_ready),
        .window      (window),
        .window_valid(window_valid),
        .window_ready(window_ready),
        .window_last (window_last),
        .win_cnt     (win_cnt),
        .oob_err     (oob_err)
    );

    task automatic check(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (oob_err) oob_cnt++;
    endtask

    task automatic pack_exp();
        for (int k = 0; k < N; k++) begin
            exp_w[k*DW +: DW] = DW'(exp_e[k]);
        end
    endtask

    task automatic send_anchor(input int r, input int c);
        int t;
        t = 0;
        while (!anchor_ready && t < 40) begin
            tick();
            t++;
        end
        anchor_valid = 1'b1;
        anchor_row   = DW'(r);
        anchor_col   = DW'(c);
        tick();
        anchor_valid = 1'b0;
        check("ready_low_in_fetch", WB'(anchor_ready), WB'(0));
    endtask

    task automatic wait_window(output int n);
        n = 0;
        while (!window_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic load_exp(input int sel);
        case (sel)
            0: exp_e = '{0,1,2,4,5,6,8,9,10, 16,17,18,20,21,22,24,25,26};
            1: exp_e = '{1,2,3,5,6,7,9,10,11, 17,18,19,21,22,23,25,26,27};
            2: exp_e = '{4,5,6,8,9,10,12,13,14, 20,21,22,24,25,26,28,29,30};
            3: exp_e = '{5,6,7,9,10,11,13,14,15, 21,22,23,25,26,27,29,30,31};
            default: exp_e = '{10,11,0,14,15,0,0,0,0, 26,27,0,30,31,0,0,0,0};
        endcase
        pack_exp();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        conv_en      = 1'b1;
        anchor_valid = 1'b0;
        anchor_row   = '0;
        anchor_col   = '0;
        window_ready = 1'b0;
        for (int k = 0; k < C*IL*IW; k++) begin
            image[k*DW +: DW] = DW'(k);
        end
        ar      = '{0, 0, 1, 1};
        ac      = '{0, 1, 0, 1};
        cnt_seq = '{1, 2, 3, 0};

        // Reset state
        tick();
        tick();
        check("rst_anchor_ready", WB'(anchor_ready), WB'(0));
        check("rst_window_valid", WB'(window_valid), WB'(0));
        check("rst_window",       window,            '0);
        check("rst_win_cnt",      WB'(win_cnt),      WB'(0));
        check("rst_window_last",  WB'(window_last),  WB'(0));
        check("rst_oob_err",      WB'(oob_err),      WB'(0));
        reset = 1'b0;
        #1;
        check("idle_anchor_ready", WB'(anchor_ready), WB'(1));

        // Anchor (0,0), downstream always ready
        window_ready = 1'b1;
        load_exp(0);
        send_anchor(0, 0);
        wait_window(lat);
        check("a00_latency", WB'(lat),         WB'(18));
        check("a00_window",  window,           exp_w);
        check("a00_last",    WB'(window_last), WB'(0));
        check("a00_cnt_hold", WB'(win_cnt),    WB'(0));
        tick();
        check("a00_valid_drop", WB'(window_valid), WB'(0));
        check("a00_cnt",        WB'(win_cnt),      WB'(1));
        check("a00_ready_back", WB'(anchor_ready), WB'(1));

        // Anchor (1,1) with a 5-cycle downstream stall
        window_ready = 1'b0;
        load_exp(3);
        send_anchor(1, 1);
        wait_window(lat);
        check("a11_latency", WB'(lat), WB'(18));
        for (int i = 0; i < 5; i++) begin
            check("a11_stall_window", window,             exp_w);
            check("a11_stall_valid",  WB'(window_valid),  WB'(1));
            check("a11_stall_aready", WB'(anchor_ready),  WB'(0));
            check("a11_stall_cnt",    WB'(win_cnt),       WB'(1));
            tick();
        end
        check("a11_after_stall", window, exp_w);
        window_ready = 1'b1;
        tick();
        check("a11_valid_drop", WB'(window_valid), WB'(0));
        check("a11_cnt",        WB'(win_cnt),      WB'(2));

        // Clear the count, then four back-to-back anchors
        conv_en = 1'b0;
        tick();
        check("clr_cnt", WB'(win_cnt), WB'(0));
        conv_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_exp(i);
            send_anchor(ar[i], ac[i]);
            wait_window(lat);
            check("seq_latency", WB'(lat),         WB'(18));
            check("seq_window",  window,           exp_w);
            check("seq_last",    WB'(window_last), WB'(i == 3));
            tick();
            check("seq_cnt",     WB'(win_cnt),     WB'(cnt_seq[i]));
        end

        // conv_en abort in the middle of a fetch
        load_exp(0);
        send_anchor(0, 0);
        wait_window(lat);
        tick();
        check("abort_pre_cnt", WB'(win_cnt), WB'(1));
        send_anchor(1, 1);
        repeat (7) tick();
        conv_en = 1'b0;
        tick();
        check("abort_valid",  WB'(window_valid), WB'(0));
        check("abort_cnt",    WB'(win_cnt),      WB'(0));
        check("abort_window", window,            '0);
        check("abort_aready", WB'(anchor_ready), WB'(0));
        conv_en = 1'b1;
        #1;
        check("abort_idle_ready", WB'(anchor_ready), WB'(1));
        load_exp(1);
        send_anchor(0, 1);
        wait_window(lat);
        check("a01_latency", WB'(lat), WB'(18));
        check("a01_window",  window,   exp_w);
        tick();

        // Reset pulse while holding a window
        window_ready = 1'b0;
        load_exp(2);
        send_anchor(1, 0);
        wait_window(lat);
        check("a10_window", window,            exp_w);
        check("a10_valid",  WB'(window_valid), WB'(1));
        reset = 1'b1;
        tick();
        check("hrst_aready", WB'(anchor_ready), WB'(0));
        check("hrst_valid",  WB'(window_valid), WB'(0));
        check("hrst_window", window,            '0);
        reset = 1'b0;
        #1;
        check("hrst_ready_back", WB'(anchor_ready), WB'(1));
        check("hrst_cnt",        WB'(win_cnt),      WB'(0));

`ifdef CONV_WINDOW_BOUNDS_CHECK_EN
        // Out-of-range anchor is zero padded and flagged once
        window_ready = 1'b1;
        oob_cnt = 0;
        load_exp(4);
        send_anchor(2, 2);
        wait_window(lat);
        check("a22_latency", WB'(lat), WB'(18));
        check("a22_window",  window,   exp_w);
        tick();
        tick();
        tick();
        check("a22_oob_pulses", WB'(oob_cnt), WB'(1));
`else
        check("no_oob_pulses", WB'(oob_cnt), WB'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
